// File: rtl/fetch_pkg.sv
// Purpose: shared types and constants for the instruction-fetch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    // Fetch sequencer states. Only one memory request is outstanding at a time.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    // Sequential fetch advances by one 32-bit instruction word.
    localparam int unsigned PC_INC = 4;

    // Default first fetch address after reset.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Purpose: instruction-memory request/response and decode handoff bundle.
// Latency: n/a (wires only).
// Backpressure: imem_ready_i stalls a request; decode_ready_i holds a delivered instruction.
//
// master: fetch sequencer side; slave: memory + decode side.
interface fetch_ctrl_if #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
);
    // instruction memory request channel
    logic                   imem_req_o;
    logic [PC_WIDTH-1:0]    imem_addr_o;
    logic                   imem_ready_i;
    // instruction memory response channel (one response per accepted request)
    logic                   imem_rvalid_i;
    logic [INSTR_WIDTH-1:0] imem_rdata_i;
    // decode handoff
    logic [INSTR_WIDTH-1:0] instr_o;
    logic [PC_WIDTH-1:0]    instr_pc_o;
    logic                   instr_valid_o;
    logic                   decode_ready_i;

    modport master (
        output imem_req_o, imem_addr_o, instr_o, instr_pc_o, instr_valid_o,
        input  imem_ready_i, imem_rvalid_i, imem_rdata_i, decode_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, instr_o, instr_pc_o, instr_valid_o,
        output imem_ready_i, imem_rvalid_i, imem_rdata_i, decode_ready_i
    );
endinterface

// File: rtl/fetch_perf_cnt.sv
// Purpose: delivered-instruction and redirect performance counters.
// Latency: counts visible one cycle after the counted event.
// Backpressure: none; counts every cycle its increment input is high.
//
// Ports: clk_i/rst_i (sync, active-high), fetch_inc/flush_inc event strobes,
//        fetch_count/flush_count 32-bit free-running wrapping counters.
module fetch_perf_cnt (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_inc,
    input  logic        flush_inc,
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            // both wrap silently at 2^32
            if (fetch_inc) fetch_count <= fetch_count + 32'd1;
            if (flush_inc) flush_count <= flush_count + 32'd1;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Purpose: fetch sequencer owning the fetch PC; one imem request at a time, hands instructions to decode.
// Latency: REQ -> WAIT -> HOLD, best case one instruction per 3 cycles with single-cycle memory.
// Backpressure: imem_ready_i low holds the request; decode_ready_i low holds the instruction and blocks new requests.
//
// Ports:
//   clk_i, rst_i          clock and synchronous active-high reset
//   stall_i               hazard hold; gates IDLE->REQ and WAIT/HOLD exits to REQ
//   ex_*                  EX-stage control-flow status; any taken redirect reloads the PC
//   pc_src_o, jalr_pc_src_o  combinational PC mux selects
//   next_pc_i             redirect target from the PC mux
//   bus                   fetch_ctrl_if.master: imem request/response and decode handoff
//   fetch_count_o, flush_count_o  perf counters, live only with FETCH_PERF_CNT_EN defined
//
// Build option: FETCH_PERF_CNT_EN enables the counters; otherwise they read as 0.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                  PC_WIDTH    = 32,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                stall_i,
    input  logic                ex_valid_i,
    input  logic                ex_branch_taken_i,
    input  logic                ex_jal_i,
    input  logic                ex_jalr_i,
    output logic                pc_src_o,
    output logic                jalr_pc_src_o,
    input  logic [PC_WIDTH-1:0] next_pc_i,
    fetch_ctrl_if.master        bus,
    output logic [31:0]         fetch_count_o,
    output logic [31:0]         flush_count_o
);

    fetch_state_e           state;
    logic [PC_WIDTH-1:0]    fetch_pc;
    logic                   kill;       // in-flight response belongs to the wrong path
    logic                   req_q;
    logic                   instr_valid_q;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic [PC_WIDTH-1:0]    instr_pc_q;

    logic redirect;
    logic handshake;

    // JALR selects its own mux input and overrides the branch/JAL select.
    assign redirect      = ex_valid_i & (ex_branch_taken_i | ex_jal_i | ex_jalr_i);
    assign pc_src_o      = ex_valid_i & (ex_branch_taken_i | ex_jal_i) & ~ex_jalr_i;
    assign jalr_pc_src_o = ex_valid_i & ex_jalr_i;

    // A redirect in the same cycle wins over decode accepting the held instruction.
    assign handshake = instr_valid_q & bus.decode_ready_i & ~redirect;

    assign bus.imem_req_o    = req_q;
    assign bus.imem_addr_o   = fetch_pc;
    assign bus.instr_o       = instr_q;
    assign bus.instr_pc_o    = instr_pc_q;
    assign bus.instr_valid_o = instr_valid_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            fetch_pc      <= RESET_PC;
            kill          <= 1'b0;
            req_q         <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
        end else begin
            // A redirect reloads the PC from any state; state-specific cleanup follows.
            if (redirect) begin
                fetch_pc <= next_pc_i;
            end

            case (state)
                IDLE: begin
                    // Responses to a request abandoned by reset land here and are ignored.
                    if (!stall_i) begin
                        state <= REQ;
                        req_q <= 1'b1;
                    end
                end

                REQ: begin
                    if (bus.imem_ready_i) begin
                        // Accepted; if redirected in the same cycle the reply is wrong-path.
                        state <= WAIT;
                        req_q <= 1'b0;
                        kill  <= redirect;
                    end
                    // Not accepted: stay in REQ; on redirect the new PC is presented next cycle.
                end

                WAIT: begin
                    if (bus.imem_rvalid_i) begin
                        kill <= 1'b0;
                        if (redirect) begin
                            state <= REQ;
                            req_q <= 1'b1;
                        end else if (kill) begin
                            state <= stall_i ? IDLE : REQ;
                            req_q <= ~stall_i;
                        end else begin
                            instr_q       <= bus.imem_rdata_i;
                            instr_pc_q    <= fetch_pc;
                            instr_valid_q <= 1'b1;
                            state         <= HOLD;
                        end
                    end else if (redirect) begin
                        kill <= 1'b1;
                    end
                end

                HOLD: begin
                    if (redirect) begin
                        instr_valid_q <= 1'b0;
                        state         <= REQ;
                        req_q         <= 1'b1;
                    end else if (handshake) begin
                        fetch_pc      <= fetch_pc + PC_WIDTH'(PC_INC);
                        instr_valid_q <= 1'b0;
                        state         <= stall_i ? IDLE : REQ;
                        req_q         <= ~stall_i;
                    end
                end

                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    fetch_perf_cnt u_perf_cnt (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .fetch_inc   (handshake),
        .flush_inc   (redirect),
        .fetch_count (fetch_count_o),
        .flush_count (flush_count_o)
    );
`else
    assign fetch_count_o = '0;
    assign flush_count_o = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Purpose: self-checking bench for fetch_ctrl with a randomized memory/decode/EX environment.
// Latency: n/a.
// Backpressure: the environment randomly withholds imem_ready_i and decode_ready_i.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, ex_valid, ex_br, ex_jal, ex_jalr;
    logic        pc_src, jalr_src;
    logic [31:0] next_pc;
    logic [31:0] fetch_cnt, flush_cnt;

    always #5 clk = ~clk;

    fetch_ctrl_if bus ();

    fetch_ctrl dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .stall_i           (stall),
        .ex_valid_i        (ex_valid),
        .ex_branch_taken_i (ex_br),
        .ex_jal_i          (ex_jal),
        .ex_jalr_i         (ex_jalr),
        .pc_src_o          (pc_src),
        .jalr_pc_src_o     (jalr_src),
        .next_pc_i         (next_pc),
        .bus               (bus),
        .fetch_count_o     (fetch_cnt),
        .flush_count_o     (flush_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // environment knobs (percent probabilities, memory latency range)
    int p_rdy, p_drdy, p_stall, p_redir, lat_min, lat_max;

    typedef struct { int cyc; logic [31:0] addr; } acc_t;
    acc_t        acc_q[$];          // accepted requests, in order
    logic [31:0] exp_q[$];          // scoreboard: PC of the next instruction decode must receive
    int          cyc;
    bit          acc_pend, mem_busy, mon_en;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          mdl_fetch, mdl_flush;
    bit          frc_redir;
    logic [2:0]  frc_kind;          // {branch, jal, jalr}
    logic [31:0] frc_tgt;

    // previous-cycle snapshot for the monitor
    bit          pv_valid, pv_hs, pv_redir, pv_req, pv_rdy;
    logic [31:0] pv_instr, pv_ipc, pv_addr, pv_tgt;
    int          idle;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit chance(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // One cycle of environment stimulus; called right after a falling edge.
    task automatic step();
        bit redir;
        cyc++;
        if (acc_pend) begin
            mem_busy = 1'b1;
            mem_cnt  = $urandom_range(lat_max, lat_min);
            acc_pend = 1'b0;
        end
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = $urandom;
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                bus.imem_rvalid_i = 1'b1;
                bus.imem_rdata_i  = word(mem_addr);
                mem_busy          = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        bus.imem_ready_i = chance(p_rdy);
        if (bus.imem_req_o) begin
            chk("one_outstanding", {31'd0, mem_busy | bus.imem_rvalid_i}, 32'd0);
            if (bus.imem_ready_i) begin
                acc_pend = 1'b1;
                mem_addr = bus.imem_addr_o;
                acc_q.push_back('{cyc, bus.imem_addr_o});
            end
        end
        bus.decode_ready_i = chance(p_drdy);
        stall              = chance(p_stall);

        redir = frc_redir || chance(p_redir);
        if (redir) begin
            ex_valid = 1'b1;
            {ex_br, ex_jal, ex_jalr} = frc_redir ? frc_kind : 3'($urandom_range(7, 1));
            next_pc  = frc_redir ? frc_tgt
                     : ($urandom_range(3) == 0 ? 32'hFFFF_FFFC : $urandom);
            exp_q.delete();
            exp_q.push_back(next_pc);
            frc_redir = 1'b0;
        end else begin
            // non-redirecting noise: valid with no control flow, or control bits without valid
            ex_valid = chance(50);
            {ex_br, ex_jal, ex_jalr} = ex_valid ? 3'b000 : 3'($urandom_range(7));
            next_pc  = $urandom;
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            step();
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input bit stall_at_release);
        mon_en = 1'b0;
        rst = 1'b1;
        stall = 1'b0; ex_valid = 1'b0; ex_br = 1'b0; ex_jal = 1'b0; ex_jalr = 1'b0;
        next_pc = '0;
        bus.imem_ready_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = '0;
        bus.decode_ready_i = 1'b0;
        mem_busy = 1'b0; acc_pend = 1'b0; frc_redir = 1'b0;
        exp_q.delete(); acc_q.delete();
        mdl_fetch = 0; mdl_flush = 0; idle = 0; cyc = 0;
        {pv_valid, pv_hs, pv_redir, pv_req, pv_rdy} = '0;
        repeat (3) @(negedge clk);
        chk("rst_req",       {31'd0, bus.imem_req_o},    32'd0);
        chk("rst_valid",     {31'd0, bus.instr_valid_o}, 32'd0);
        chk("rst_instr",     bus.instr_o,                32'd0);
        chk("rst_instr_pc",  bus.instr_pc_o,             32'd0);
        chk("rst_addr",      bus.imem_addr_o,            32'h0);
        chk("rst_fetch_cnt", fetch_cnt,                  32'd0);
        chk("rst_flush_cnt", flush_cnt,                  32'd0);
        rst = 1'b0;
        stall = stall_at_release;
        exp_q.push_back(32'h0);
        mon_en = 1'b1;
    endtask

    task automatic set_knobs(input int r, input int d, input int s, input int x,
                             input int lmin, input int lmax);
        p_rdy = r; p_drdy = d; p_stall = s; p_redir = x; lat_min = lmin; lat_max = lmax;
    endtask

    // Monitor: samples between the falling-edge stimulus and the next rising edge.
    initial begin
        logic [31:0] e, exp_f, exp_x;
        bit hs, redir;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                redir = ex_valid & (ex_br | ex_jal | ex_jalr);
                chk("pc_src",   {31'd0, pc_src},   {31'd0, ex_valid & (ex_br | ex_jal) & ~ex_jalr});
                chk("jalr_src", {31'd0, jalr_src}, {31'd0, ex_valid & ex_jalr});
`ifdef FETCH_PERF_CNT_EN
                exp_f = mdl_fetch; exp_x = mdl_flush;
`else
                exp_f = 0; exp_x = 0;
`endif
                chk("fetch_count", fetch_cnt, exp_f);
                chk("flush_count", flush_cnt, exp_x);
                if (pv_redir) begin
                    chk("valid_after_redirect", {31'd0, bus.instr_valid_o}, 32'd0);
                end else if (pv_valid && !pv_hs) begin
                    chk("hold_valid", {31'd0, bus.instr_valid_o}, 32'd1);
                    chk("hold_instr", bus.instr_o,    pv_instr);
                    chk("hold_pc",    bus.instr_pc_o, pv_ipc);
                end
                if (bus.instr_valid_o)
                    chk("no_req_while_valid", {31'd0, bus.imem_req_o}, 32'd0);
                if (pv_req && !pv_rdy) begin
                    chk("req_held", {31'd0, bus.imem_req_o}, 32'd1);
                    chk("req_addr", bus.imem_addr_o, pv_redir ? pv_tgt : pv_addr);
                end
                hs = bus.instr_valid_o & bus.decode_ready_i & ~redir;
                if (hs) begin
                    if (exp_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL sb_empty: delivery at pc %h with nothing expected", bus.instr_pc_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("deliver_pc",    bus.instr_pc_o, e);
                        chk("deliver_instr", bus.instr_o,    word(e));
                        exp_q.push_back(e + 32'd4);
                    end
                    mdl_fetch++;
                    idle = 0;
                end else begin
                    idle++;
                    if (idle > 300) begin
                        n_tests++; n_fail++;
                        $display("FAIL watchdog: no delivery for %0d cycles, required <= 300", idle);
                        idle = 0;
                    end
                end
                if (redir) mdl_flush++;
                pv_valid = bus.instr_valid_o; pv_hs = hs; pv_redir = redir;
                pv_req = bus.imem_req_o; pv_rdy = bus.imem_ready_i;
                pv_instr = bus.instr_o; pv_ipc = bus.instr_pc_o;
                pv_addr = bus.imem_addr_o; pv_tgt = next_pc;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        mon_en = 1'b0;
        @(negedge clk);

        // back-to-back fetch: REQ/WAIT/HOLD every 3 cycles
        set_knobs(100, 100, 0, 0, 0, 0);
        do_reset(1'b0);
        run(10);
        chk("thr_count", acc_q.size() >= 3, 32'd1);
        if (acc_q.size() >= 3) begin
            chk("thr_addr0", acc_q[0].addr, 32'h0);
            chk("thr_addr1", acc_q[1].addr, 32'h4);
            chk("thr_addr2", acc_q[2].addr, 32'h8);
            chk("thr_gap1", 32'(acc_q[1].cyc - acc_q[0].cyc), 32'd3);
            chk("thr_gap2", 32'(acc_q[2].cyc - acc_q[1].cyc), 32'd3);
        end

        // decode backpressure holds the instruction and blocks new requests
        set_knobs(100, 0, 0, 0, 0, 0);
        do_reset(1'b0);
        run(10);
        chk("hold_no_new_req", acc_q.size(), 32'd1);
        p_drdy = 100;
        run(4);
        chk("hold_release_req", acc_q.size() >= 2, 32'd1);
        if (acc_q.size() >= 2) chk("hold_release_addr", acc_q[1].addr, 32'h4);

        // JAL+JALR redirect while waiting; stale response arrives 2 cycles later
        set_knobs(100, 100, 0, 0, 2, 2);
        do_reset(1'b0);
        for (int i = 0; i < 20 && acc_q.size() == 0; i++) run(1);
        frc_redir = 1'b1; frc_kind = 3'b011; frc_tgt = 32'h100;
        run(12);
        chk("jalr_redirect_req", acc_q.size() >= 2, 32'd1);
        if (acc_q.size() >= 2) chk("jalr_redirect_addr", acc_q[1].addr, 32'h100);

        // branch redirect while the request is not being accepted
        set_knobs(0, 100, 0, 0, 0, 0);
        do_reset(1'b0);
        run(3);
        frc_redir = 1'b1; frc_kind = 3'b100; frc_tgt = 32'h200;
        run(2);
        chk("req_redir_req",  {31'd0, bus.imem_req_o}, 32'd1);
        chk("req_redir_addr", bus.imem_addr_o,         32'h200);
        p_rdy = 100;
        run(3);
        chk("req_redir_acc", acc_q.size() >= 1, 32'd1);
        if (acc_q.size() >= 1) chk("req_redir_acc_addr", acc_q[0].addr, 32'h200);

        // stall from reset, redirect during the stall
        set_knobs(100, 100, 100, 0, 0, 0);
        do_reset(1'b1);
        run(2);
        frc_redir = 1'b1; frc_kind = 3'b010; frc_tgt = 32'h40;
        run(2);
        chk("stall_no_req", acc_q.size(), 32'd0);
        p_stall = 0;
        run(4);
        chk("stall_first_req", acc_q.size() >= 1, 32'd1);
        if (acc_q.size() >= 1) chk("stall_first_addr", acc_q[0].addr, 32'h40);

        // PC wraps from the top of the address space
        set_knobs(100, 100, 0, 0, 0, 0);
        do_reset(1'b0);
        frc_redir = 1'b1; frc_kind = 3'b100; frc_tgt = 32'hFFFF_FFFC;
        run(12);
        chk("wrap_reqs", acc_q.size() >= 2, 32'd1);
        if (acc_q.size() >= 2) begin
            chk("wrap_addr0", acc_q[0].addr, 32'hFFFF_FFFC);
            chk("wrap_addr1", acc_q[1].addr, 32'h0);
        end

        // randomized mix of everything
        set_knobs(60, 60, 20, 6, 0, 3);
        do_reset(1'b0);
        run(3000);
        chk("random_deliveries", mdl_fetch > 100, 32'd1);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
